seg_scan_ctrl: RTL and testbench

Scan and update controller for the multiplexed seven-segment display on the board. It time-shares the single 3-bit state decoder across all digit positions by driving the active-low anode enables in rotation. It accepts game-state code updates from the control logic and commits them only at frame boundaries, so a digit never shows a half-updated frame. It also provides an optional frame-based blink.

---
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// -----------------------------------------------------------------------------
// Scan and update controller for the multiplexed seven-segment display.
// One shared 3-bit state decoder is time-shared across DIGITS positions by
// rotating the active-low anode enables. State-code updates are staged in a
// pending register and committed only at frame boundaries, so no digit ever
// shows a half-updated frame. An optional frame-based blink blanks the display.
//
// Parameters
//   DIGITS        number of scanned digit positions (>= 2)
//   SCAN_DIV      clock cycles each digit stays enabled (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports
//   CLK100MHZ       in   system clock, rising edge
//   CPU_RESETN      in   asynchronous active-low reset
//   state_in        in   requested state code, valid 3'b001..3'b100
//   state_load      in   single-cycle strobe qualifying state_in
//   blink           in   level, 1 = blink the whole display
//   digit_mask      in   per-position enable, 1 = position is scanned
//   state_code      out  registered code feeding the state decoder
//   AN              out  registered active-low anode enables
//   update_pending  out  a valid code waits for the next frame boundary
//   load_err        out  one-cycle pulse when an invalid code is rejected
//   frame_tick      out  one-cycle pulse at each frame wrap
// -----------------------------------------------------------------------------

// One anode lane: registered, active-low enable for a single digit position.
module seg_scan_an_lane #(
    parameter int IW   = 2,
    parameter int LANE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] idx_next,
    input  logic          en,
    input  logic          visible_next,
    output logic          an
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) an <= 1'b1;
        else        an <= ~((idx_next == IW'(LANE)) & en & visible_next);
    end
endmodule

module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [2:0]        state_in,
    input  logic              state_load,
    input  logic              blink,
    input  logic [DIGITS-1:0] digit_mask,
    output logic [2:0]        state_code,
    output logic [DIGITS-1:0] AN,
    output logic              update_pending,
    output logic              load_err,
    output logic              frame_tick
);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] presc;
    logic [IW-1:0] idx, idx_next;
    logic [BW-1:0] bcnt, bcnt_next;
    logic          visible, visible_next;
    logic [2:0]    pending;
    logic          scan_tick, frame_wrap;
    logic          code_valid, load_ok, load_bad;

    assign scan_tick  = (presc == PW'(SCAN_DIV - 1));
    assign frame_wrap = scan_tick && (idx == IW'(DIGITS - 1));

    // Only codes 1..4 drive a meaningful decoder pattern.
    assign code_valid = (state_in != 3'd0) && (state_in <= 3'd4);
    assign load_ok    = state_load &  code_valid;
    assign load_bad   = state_load & ~code_valid;

    // ---------------- prescaler and digit index ----------------
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN)    presc <= '0;
        else if (scan_tick) presc <= '0;
        else                presc <= presc + PW'(1);
    end

    always_comb begin
        idx_next = idx;
        if (scan_tick) begin
            if (idx == IW'(DIGITS - 1)) idx_next = '0;
            else                        idx_next = idx + IW'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) idx <= '0;
        else             idx <= idx_next;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) frame_tick <= 1'b0;
        else             frame_tick <= frame_wrap;
    end

    // ---------------- blink ----------------
    // With blink low the display is forced visible and the phase restarts,
    // so re-enabling blink always begins with a full visible half-period.
    always_comb begin
        bcnt_next    = bcnt;
        visible_next = visible;
        if (!blink) begin
            bcnt_next    = '0;
            visible_next = 1'b1;
        end else if (frame_wrap) begin
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                bcnt_next    = '0;
                visible_next = ~visible;
            end else begin
                bcnt_next    = bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            bcnt    <= '0;
            visible <= 1'b1;
        end else begin
            bcnt    <= bcnt_next;
            visible <= visible_next;
        end
    end

    // ---------------- load staging and frame-aligned commit ----------------
    // On a load that collides with a commit, the old pending value is the one
    // committed; the new value stays pending for the following frame.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_code     <= 3'b001;
            pending        <= 3'b001;
            update_pending <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            load_err <= load_bad;
            if (frame_wrap && update_pending)
                state_code <= pending;
            if (load_ok) begin
                pending        <= state_in;
                update_pending <= 1'b1;
            end else if (frame_wrap) begin
                update_pending <= 1'b0;
            end
        end
    end

    // ---------------- anode lanes ----------------
    // Each lane is driven from idx_next so AN lines up with the new index on
    // the same edge that advances it; only one lane can match idx_next.
    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
        seg_scan_an_lane #(.IW(IW), .LANE(i)) u_lane (
            .clk          (CLK100MHZ),
            .rst_n        (CPU_RESETN),
            .idx_next     (idx_next),
            .en           (digit_mask[i]),
            .visible_next (visible_next),
            .an           (AN[i])
        );
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// Expected outputs for each clock are pushed to a scoreboard queue before the
// edge and popped/compared after it. Cycle k counts edges since reset release.
module tb_seg_scan_ctrl;
    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic              CLK100MHZ  = 1'b0;
    logic              CPU_RESETN = 1'b0;
    logic [2:0]        state_in   = 3'd0;
    logic              state_load = 1'b0;
    logic              blink      = 1'b0;
    logic [DIGITS-1:0] digit_mask = 4'b1111;
    logic [2:0]        state_code;
    logic [DIGITS-1:0] AN;
    logic              update_pending;
    logic              load_err;
    logic              frame_tick;

    seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .CLK100MHZ      (CLK100MHZ),
        .CPU_RESETN     (CPU_RESETN),
        .state_in       (state_in),
        .state_load     (state_load),
        .blink          (blink),
        .digit_mask     (digit_mask),
        .state_code     (state_code),
        .AN             (AN),
        .update_pending (update_pending),
        .load_err       (load_err),
        .frame_tick     (frame_tick)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [2:0] code;
        logic       pend;
        logic       err;
        logic       ft;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         kk;
    logic [2:0] m_code, m_val;
    logic       m_pend;
    string      cur_tag;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s k=%0d: observed=%0h expected=%0h", tag, kk, got, exp);
        end
    endtask

    task automatic model_reset();
        kk     = 0;
        m_code = 3'b001;
        m_val  = 3'b001;
        m_pend = 1'b0;
    endtask

    // One clock: derive expectations for edge k from the current inputs,
    // push them, clock, then pop and compare against the DUT.
    task automatic cyc();
        exp_t       e;
        logic       valid, commit, vis;
        int         di;
        logic [3:0] oh;
        kk++;
        valid  = state_load && (state_in >= 3'd1) && (state_in <= 3'd4);
        e.ft   = (kk % FRAME == 0);
        commit = e.ft && m_pend;
        if (commit) m_code = m_val;
        if (valid) begin
            m_val  = state_in;
            m_pend = 1'b1;
        end else if (commit) begin
            m_pend = 1'b0;
        end
        e.err  = state_load && !valid;
        di     = (kk / SCAN_DIV) % DIGITS;
        // blink is only ever raised at reset release, so the phase is
        // visible for BLINK_FRAMES frames, then dark for BLINK_FRAMES frames.
        vis    = !blink || ((kk / (BLINK_FRAMES * FRAME)) % 2 == 0);
        oh     = 4'b0001 << di;
        e.an   = ~(oh & digit_mask & {4{vis}});
        e.code = m_code;
        e.pend = m_pend;
        e.tag  = cur_tag;
        sb.push_back(e);
        @(posedge CLK100MHZ);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_an"},   {4'd0, AN},         {4'd0, e.an});
        chk({e.tag, "_code"}, {5'd0, state_code}, {5'd0, e.code});
        chk({e.tag, "_pend"}, {7'd0, update_pending}, {7'd0, e.pend});
        chk({e.tag, "_err"},  {7'd0, load_err},   {7'd0, e.err});
        chk({e.tag, "_ft"},   {7'd0, frame_tick}, {7'd0, e.ft});
        chk({e.tag, "_onelow"}, {7'd0, ($countones(~AN) <= 1)}, 8'd1);
    endtask

    task automatic cyc_load(input logic [2:0] v);
        state_load = 1'b1;
        state_in   = v;
        cyc();
        state_load = 1'b0;
        state_in   = 3'd0;
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge CLK100MHZ);
        #1;
        chk("rst_an",   {4'd0, AN}, 8'h0F);
        chk("rst_code", {5'd0, state_code}, 8'd1);
        chk("rst_pend", {7'd0, update_pending}, 8'd0);
        chk("rst_err",  {7'd0, load_err}, 8'd0);
        chk("rst_ft",   {7'd0, frame_tick}, 8'd0);
        CPU_RESETN = 1'b1;
        model_reset();

        // ---- scan rotation ----
        cur_tag = "scan";
        repeat (40) cyc();

        // ---- masking ----
        cur_tag    = "mask";
        digit_mask = 4'b0101;
        repeat (20) cyc();
        digit_mask = 4'b1111;

        // ---- frame-aligned commit ----
        cur_tag = "commit";
        while (kk % FRAME != 5) cyc();
        cyc_load(3'b011);
        while (kk % FRAME != 0) cyc();
        chk("commit_code", {5'd0, state_code}, 8'd3);
        chk("commit_pend", {7'd0, update_pending}, 8'd0);

        // ---- overwrite: latest load wins ----
        cur_tag = "ovwr";
        while (kk % FRAME != 3) cyc();
        cyc_load(3'b010);
        repeat (4) cyc();
        cyc_load(3'b100);
        while (kk % FRAME != 0) cyc();
        chk("ovwr_code", {5'd0, state_code}, 8'd4);

        // ---- collision: load on the commit cycle ----
        cur_tag = "coll";
        while (kk % FRAME != 4) cyc();
        cyc_load(3'b010);
        while (kk % FRAME != 15) cyc();
        cyc_load(3'b011);
        chk("coll_code1", {5'd0, state_code}, 8'd2);
        chk("coll_pend1", {7'd0, update_pending}, 8'd1);
        repeat (FRAME) cyc();
        chk("coll_code2", {5'd0, state_code}, 8'd3);
        chk("coll_pend2", {7'd0, update_pending}, 8'd0);

        // ---- invalid loads, with and without a pending value ----
        cur_tag = "inval";
        cyc_load(3'b111);
        cyc();
        cyc_load(3'b010);
        cyc_load(3'b000);
        cyc();
        chk("inval_pend", {7'd0, update_pending}, 8'd1);
        while (kk % FRAME != 0) cyc();
        chk("inval_code", {5'd0, state_code}, 8'd2);

        // ---- blink from a fresh reset ----
        CPU_RESETN = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        blink      = 1'b1;
        CPU_RESETN = 1'b1;
        model_reset();
        cur_tag = "blink";
        while (kk < 50) cyc();
        cyc_load(3'b011);
        while (kk < 72) cyc();
        cyc_load(3'b100);
        cyc();
        cyc();
        chk("pre_rst_code", {5'd0, state_code}, 8'd3);
        chk("pre_rst_pend", {7'd0, update_pending}, 8'd1);

        // ---- asynchronous reset mid-frame, no clock edge in between ----
        #2;
        CPU_RESETN = 1'b0;
        #1;
        chk("arst_an",   {4'd0, AN}, 8'h0F);
        chk("arst_code", {5'd0, state_code}, 8'd1);
        chk("arst_pend", {7'd0, update_pending}, 8'd0);
        chk("arst_ft",   {7'd0, frame_tick}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
